// File: rtl/dist_ram_pkg.sv
// Shared definitions for the dist_ram read-side burst engine.
//   rd_state_e  - burst FSM state encoding
//   word_width  - RAM word width from column count and column width
package dist_ram_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2
    } rd_state_e;

    function automatic int unsigned word_width(input int unsigned num_col,
                                               input int unsigned col_width);
        return num_col * col_width;
    endfunction

endpackage

// File: rtl/dist_ram_rd_skid.sv
// Two-entry FIFO holding RAM read words (plus last flag) between the RAM
// port and the output stream.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i          write data_i/last_i into the tail slot
//   pop_i           drop the head slot
//   data_o, last_o  head slot contents (stale when count_o == 0)
//   count_o         number of occupied slots, 0..2
module dist_ram_rd_skid #(
    parameter int unsigned WIDTH = 512
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] data_q [2];
    logic [1:0]       last_q;
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q    <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push_i) begin
                data_q[wr_ptr_q] <= data_i;
                last_q[wr_ptr_q] <= last_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: ;
            endcase
        end
    end

    assign data_o  = data_q[rd_ptr_q];
    assign last_o  = last_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/dist_ram_burst_reader.sv
// Read-side burst engine for one dist_ram port. Accepts (addr, len) commands,
// issues one RAM read per cycle while buffer space allows, absorbs the RAM's
// one-cycle registered read latency and returns the words as a valid/ready
// stream with a last flag.
//   clock, reset_n          clock, asynchronous active-low reset
//   cmd_valid/ready         command handshake; cmd_addr first word, cmd_len beats
//   ram_wen/addr/din/dout   RAM port (read only: wen and din tied to zero)
//   rd_valid/ready          output beat handshake; rd_data word, rd_last final beat
//   busy                    burst in progress or beats still buffered
module dist_ram_burst_reader
    import dist_ram_pkg::*;
#(
    parameter int unsigned NUM_COL    = 16,
    parameter int unsigned COL_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                                       clock,
    input  logic                                       reset_n,
    input  logic                                       cmd_valid,
    output logic                                       cmd_ready,
    input  logic [ADDR_WIDTH-1:0]                      cmd_addr,
    input  logic [ADDR_WIDTH:0]                        cmd_len,
    output logic [NUM_COL-1:0]                         ram_wen,
    output logic [ADDR_WIDTH-1:0]                      ram_addr,
    output logic [word_width(NUM_COL, COL_WIDTH)-1:0]  ram_din,
    input  logic [word_width(NUM_COL, COL_WIDTH)-1:0]  ram_dout,
    output logic                                       rd_valid,
    input  logic                                       rd_ready,
    output logic [word_width(NUM_COL, COL_WIDTH)-1:0]  rd_data,
    output logic                                       rd_last,
    output logic                                       busy
);

    localparam int unsigned WordW = word_width(NUM_COL, COL_WIDTH);
    localparam int unsigned LenW  = ADDR_WIDTH + 1;

    rd_state_e             state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LenW-1:0]       issue_left_q;
    // Read issued last cycle: its word is on ram_dout this cycle.
    logic                  inflight_q;
    logic                  inflight_last_q;

    logic                  issue;
    logic                  pop;
    logic [1:0]            skid_count;
    logic                  skid_last;

    assign pop = rd_valid & rd_ready;

    // Entries plus in-flight never exceed 2; a same-cycle pop frees a slot.
    assign issue = (state_q == StIssue) &&
                   (((skid_count + {1'b0, inflight_q}) < 2'd2) || pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            issue_left_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue && (issue_left_q == LenW'(1));
            unique case (state_q)
                StIdle: begin
                    // Zero-length commands are accepted and dropped here.
                    if (cmd_valid && (cmd_len != '0)) begin
                        addr_q       <= cmd_addr;
                        issue_left_q <= cmd_len;
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
                    if (issue) begin
                        addr_q       <= addr_q + ADDR_WIDTH'(1);
                        issue_left_q <= issue_left_q - LenW'(1);
                        if (issue_left_q == LenW'(1)) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (pop && rd_last) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    dist_ram_rd_skid #(
        .WIDTH (WordW)
    ) u_skid (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (inflight_q),
        .data_i  (ram_dout),
        .last_i  (inflight_last_q),
        .pop_i   (pop),
        .data_o  (rd_data),
        .last_o  (skid_last),
        .count_o (skid_count)
    );

    assign cmd_ready = (state_q == StIdle);
    assign ram_wen   = '0;
    assign ram_din   = '0;
    assign ram_addr  = addr_q;
    assign rd_valid  = (skid_count != 2'd0);
    // The head slot keeps a stale flag once drained; only report it with a beat.
    assign rd_last   = skid_last & rd_valid;
    assign busy      = (state_q != StIdle) | rd_valid;

endmodule

// File: tb/tb_dist_ram_burst_reader.sv
// Self-checking bench for dist_ram_burst_reader: a behavioural registered-read
// RAM, a table of bursts, randomized bursts with random backpressure, and
// hand-written zero-length and reset-mid-burst sequences.
module tb_dist_ram_burst_reader;
    import dist_ram_pkg::*;

    localparam int NC    = 16;
    localparam int CW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;
    localparam int WORD  = NC * CW;

    logic            clock;
    logic            reset_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [AW-1:0]   cmd_addr;
    logic [AW:0]     cmd_len;
    logic [NC-1:0]   ram_wen;
    logic [AW-1:0]   ram_addr;
    logic [WORD-1:0] ram_din;
    logic [WORD-1:0] ram_dout;
    logic            rd_valid;
    logic            rd_ready;
    logic [WORD-1:0] rd_data;
    logic            rd_last;
    logic            busy;

    logic [WORD-1:0] mem [DEPTH];
    int n_chk;
    int n_pass;

    dist_ram_burst_reader #(
        .NUM_COL    (NC),
        .COL_WIDTH  (CW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM port model: enable tied high, one-cycle registered read.
    always @(posedge clock) ram_dout <= mem[ram_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_word(input string name, input logic [WORD-1:0] act,
                              input logic [WORD-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called and returns at a falling edge. exp_lat counts rising edges after
    // the accepting edge up to the edge that raises the first rd_valid.
    task automatic run_burst(input int addr, input int len, input bit rnd,
                             input int exp_lat, input int exp_beats);
        logic [WORD-1:0] q_data[$];
        bit              q_last[$];
        int              k, beats, first_k, stall, off;
        bit              prev_stall;
        logic [WORD-1:0] prev_data;
        logic            prev_last;
        for (int i = 0; i < len; i++) begin
            q_data.push_back(mem[(addr + i) % DEPTH]);
            q_last.push_back(i == len - 1);
        end
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = AW'(addr);
        cmd_len   = (AW + 1)'(len);
        rd_ready  = 1'b1;
        @(negedge clock);
        cmd_valid  = 1'b0;
        k          = 1;
        beats      = 0;
        first_k    = -1;
        stall      = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        while (beats < len && k < len * 20 + 50) begin
            if (!rnd) begin
                rd_ready = 1'b1;
            end else if (stall > 0) begin
                rd_ready = 1'b0;
                stall--;
            end else if (k == 4 || $urandom_range(0, 7) == 0) begin
                rd_ready = 1'b0;
                stall    = 4;
            end else begin
                rd_ready = ($urandom_range(0, 2) != 0);
            end
            #1;
            check("busy_in_burst", busy, 1);
            if (!rnd && k <= len) check("ram_addr_seq", ram_addr, (addr + k - 1) % DEPTH);
            if (rnd) begin
                // Reads issued so far minus beats taken = words held or in flight.
                off = (int'(ram_addr) - addr) & (DEPTH - 1);
                check("outstanding_le_2", ((off - beats) <= 2), 1);
            end
            if (prev_stall) begin
                check("stall_valid", rd_valid, 1);
                check_word("stall_data", rd_data, prev_data);
                check("stall_last", rd_last, prev_last);
            end
            if (rd_valid && first_k < 0) first_k = k;
            if (rd_valid && rd_ready) begin
                check_word("beat_data", rd_data, q_data.pop_front());
                check("beat_last", rd_last, q_last.pop_front());
                beats++;
                if (!rnd) check("beat_cycle", k, beats + 2);
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            prev_last  = rd_last;
            @(negedge clock);
            k++;
        end
        check("beat_count", beats, exp_beats);
        check("first_latency", first_k - 1, exp_lat);
        #1;
        check("cmd_ready_after", cmd_ready, 1);
        check("busy_after", busy, 0);
        check("no_extra_valid", rd_valid, 0);
        check("no_stale_last", rd_last, 0);
        @(negedge clock);
        #1;
        check("no_extra_valid2", rd_valid, 0);
        @(negedge clock);
    endtask

    typedef struct {
        int addr;
        int len;
        bit rnd;
        int exp_lat;
        int exp_beats;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int beats, k;
        n_chk = 0;
        n_pass = 0;
        vecs[0] = '{addr: 3,  len: 4,  rnd: 1'b0, exp_lat: 2, exp_beats: 4};
        vecs[1] = '{addr: 30, len: 4,  rnd: 1'b0, exp_lat: 2, exp_beats: 4};
        vecs[2] = '{addr: 11, len: 8,  rnd: 1'b1, exp_lat: 2, exp_beats: 8};
        vecs[3] = '{addr: 0,  len: 32, rnd: 1'b0, exp_lat: 2, exp_beats: 32};
        vecs[4] = '{addr: 31, len: 1,  rnd: 1'b0, exp_lat: 2, exp_beats: 1};
        vecs[5] = '{addr: 17, len: 2,  rnd: 1'b1, exp_lat: 2, exp_beats: 2};

        for (int d = 0; d < DEPTH; d++)
            for (int c = 0; c < NC; c++) mem[d][c*CW +: CW] = $urandom();

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        rd_ready  = 1'b0;
        #1;
        check("rst_ram_addr", ram_addr, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_last", rd_last, 0);
        check_word("rst_rd_data", rd_data, '0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("ram_wen_zero", ram_wen, 0);
        check_word("ram_din_zero", ram_din, '0);

        for (int v = 0; v < 6; v++)
            run_burst(vecs[v].addr, vecs[v].len, vecs[v].rnd, vecs[v].exp_lat,
                      vecs[v].exp_beats);

        // Zero-length command: accepted at once, no beats, never busy.
        check("len0_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = AW'(9);
        cmd_len   = '0;
        rd_ready  = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("len0_valid", rd_valid, 0);
            check("len0_busy", busy, 0);
            check("len0_cmd_ready", cmd_ready, 1);
            @(negedge clock);
        end

        // Reset after 3 of 8 beats.
        cmd_valid = 1'b1;
        cmd_addr  = AW'(5);
        cmd_len   = (AW + 1)'(8);
        rd_ready  = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        beats = 0;
        k = 0;
        while (beats < 3 && k < 20) begin
            #1;
            if (rd_valid && rd_ready) begin
                check_word("pre_rst_data", rd_data, mem[(5 + beats) % DEPTH]);
                beats++;
            end
            @(negedge clock);
            k++;
        end
        check("pre_rst_beats", beats, 3);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", rd_valid, 0);
        check("mid_rst_last", rd_last, 0);
        check_word("mid_rst_data", rd_data, '0);
        check("mid_rst_addr", ram_addr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            #1;
            check("in_rst_valid", rd_valid, 0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("post_rst_no_beat", rd_valid, 0);
            @(negedge clock);
        end
        run_burst(9, 5, 1'b0, 2, 5);

        // Randomized bursts with random backpressure.
        for (int r = 0; r < 12; r++) begin
            int a, l;
            a = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(1, DEPTH - 1);
            run_burst(a, l, 1'b1, 2, l);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
